// File: rtl/relay_pkg.sv
// Shared types for the relay ALU sequencer:
// opcode, destination, FSM state and captured request.
package relay_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_INC = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_CLR = 3'b111
  } alu_op_t;

  typedef enum logic {
    DEST_A = 1'b0,
    DEST_D = 1'b1
  } dest_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  typedef struct packed {
    alu_op_t    op;
    dest_t      dest;
    logic [7:0] b;
    logic [7:0] c;
  } alu_req_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/result bundle between the register file
// controller and the ALU sequencer.
interface alu_sequencer_if;
  import relay_pkg::*;

  logic       start;
  alu_op_t    op;
  dest_t      dest;
  logic [7:0] b;
  logic [7:0] c;
  logic       busy;
  logic       done;
  logic [7:0] alu_result;
  logic       ldA;
  logic       ldD;
  logic       flag_z;
  logic       flag_c;
  logic       flag_s;

  modport master (
    output start, op, dest, b, c,
    input  busy, done, alu_result,
    input  ldA, ldD, flag_z, flag_c, flag_s
  );

  modport slave (
    input  start, op, dest, b, c,
    output busy, done, alu_result,
    output ldA, ldD, flag_z, flag_c, flag_s
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: op, b, c -> result, carry.
// Carry is only meaningful for ADD and INC.
module alu_core
  import relay_pkg::*;
(
  input  alu_op_t    op,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic [7:0] result,
  output logic       carry
);

  always_comb begin
    result = 8'h00;
    carry  = 1'b0;
    unique case (op)
      OP_ADD: {carry, result} = {1'b0, b} + {1'b0, c};
      OP_INC: {carry, result} = {1'b0, b} + 9'd1;
      OP_AND: result = b & c;
      OP_OR:  result = b | c;
      OP_XOR: result = b ^ c;
      OP_NOT: result = ~b;
      OP_SHL: result = {b[6:0], b[7]};
      OP_CLR: result = 8'h00;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Relay ALU sequencer: captures a request, waits the
// relay settle time, then registers and strobes the result.
module alu_sequencer
  import relay_pkg::*;
#(
  parameter int unsigned SETTLE = 3
) (
  input  logic            clock,
  input  logic            reset,
  alu_sequencer_if.slave  bus
);

  state_t     state;
  logic [3:0] cnt;
  alu_req_t   req;
  logic [7:0] result;
  logic       fz;
  logic       fc;
  logic       fs;
  logic [7:0] res_d;
  logic       carry_d;

  alu_core u_core (
    .op     (req.op),
    .b      (req.b),
    .c      (req.c),
    .result (res_d),
    .carry  (carry_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      req    <= '0;
      result <= 8'h00;
      fz     <= 1'b1;
      fc     <= 1'b0;
      fs     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            req   <= '{op: bus.op, dest: bus.dest,
                       b: bus.b, c: bus.c};
            cnt   <= 4'(SETTLE - 1);
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == 4'd0) begin
            result <= res_d;
            fz     <= (res_d == 8'h00);
            fc     <= carry_d;
            fs     <= res_d[7];
            state  <= ST_WRITE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_WRITE);
  assign bus.ldA        = bus.done && (req.dest == DEST_A);
  assign bus.ldD        = bus.done && (req.dest == DEST_D);
  assign bus.alu_result = result;
  assign bus.flag_z     = fz;
  assign bus.flag_c     = fc;
  assign bus.flag_s     = fs;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: vector table, scoreboard,
// held-start, abort and settle-time corner cases.
module tb_alu_sequencer;
  import relay_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if i3 ();
  alu_sequencer_if i1 ();
  alu_sequencer_if i15 ();

  alu_sequencer #(.SETTLE(3)) dut3 (
    .clock(clk), .reset(rst), .bus(i3.slave));
  alu_sequencer #(.SETTLE(1)) dut1 (
    .clock(clk), .reset(rst), .bus(i1.slave));
  alu_sequencer #(.SETTLE(15)) dut15 (
    .clock(clk), .reset(rst), .bus(i15.slave));

  typedef struct {
    alu_op_t    op;
    dest_t      dest;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] r;
    logic       z;
    logic       cy;
    logic       s;
  } vec_t;

  typedef struct {
    logic [7:0] r;
    logic       z;
    logic       cy;
    logic       s;
    dest_t      dest;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  vec_t vt[11];
  int total = 0;
  int bad = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Scoreboard: every completion of the SETTLE=3 unit pops one entry.
  always @(negedge clk) begin
    if (i3.done || i3.ldA || i3.ldD) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: done=%0b ldA=%0b ldD=%0b",
                 i3.done, i3.ldA, i3.ldD);
      end else begin
        e = sbq.pop_front();
        chk("sb_done", i3.done, 1);
        chk("sb_result", i3.alu_result, e.r);
        chk("sb_z", i3.flag_z, e.z);
        chk("sb_c", i3.flag_c, e.cy);
        chk("sb_s", i3.flag_s, e.s);
        chk("sb_ldA", i3.ldA, e.dest == DEST_A);
        chk("sb_ldD", i3.ldD, e.dest == DEST_D);
      end
    end
  end

  task automatic put(int sel, logic st, alu_op_t op, dest_t d,
                     logic [7:0] b, logic [7:0] c);
    case (sel)
      1: begin
        i1.start = st; i1.op = op; i1.dest = d;
        i1.b = b; i1.c = c;
      end
      15: begin
        i15.start = st; i15.op = op; i15.dest = d;
        i15.b = b; i15.c = c;
      end
      default: begin
        i3.start = st; i3.op = op; i3.dest = d;
        i3.b = b; i3.c = c;
      end
    endcase
  endtask

  function automatic logic done_of(int sel);
    case (sel)
      1:  return i1.done;
      15: return i15.done;
      default: return i3.done;
    endcase
  endfunction

  function automatic logic busy_of(int sel);
    case (sel)
      1:  return i1.busy;
      15: return i15.busy;
      default: return i3.busy;
    endcase
  endfunction

  function automatic logic [8:0] res_of(int sel);
    case (sel)
      1:  return {i1.flag_z, i1.alu_result};
      15: return {i15.flag_z, i15.alu_result};
      default: return {i3.flag_z, i3.alu_result};
    endcase
  endfunction

  // One operation; sel is also the settle time of that unit,
  // so done must appear exactly sel edges after the accept edge.
  task automatic run_op(int sel, alu_op_t op, dest_t d,
                        logic [7:0] b, logic [7:0] c,
                        string name);
    int lat;
    bit seen;
    @(negedge clk);
    put(sel, 1'b1, op, d, b, c);
    @(posedge clk);
    #1;
    put(sel, 1'b0, alu_op_t'($urandom_range(7)),
        dest_t'($urandom_range(1)), 8'h00, 8'($urandom));
    chk({name, "_busy"}, busy_of(sel), 1);
    seen = 0;
    lat = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done_of(sel)) begin
        seen = 1;
        lat = i;
      end
    end
    chk({name, "_latency"}, lat, sel);
    @(posedge clk);
    #1;
    chk({name, "_idle"}, busy_of(sel), 0);
  endtask

  initial begin
    int dc;
    int last;
    vt[0]  = '{OP_ADD, DEST_D, 8'hFF, 8'h01, 8'h00, 1, 1, 0};
    vt[1]  = '{OP_SHL, DEST_A, 8'h81, 8'h00, 8'h03, 0, 0, 0};
    vt[2]  = '{OP_NOT, DEST_A, 8'h0F, 8'h33, 8'hF0, 0, 0, 1};
    vt[3]  = '{OP_AND, DEST_D, 8'hF0, 8'h3C, 8'h30, 0, 0, 0};
    vt[4]  = '{OP_OR,  DEST_A, 8'h0F, 8'h30, 8'h3F, 0, 0, 0};
    vt[5]  = '{OP_XOR, DEST_D, 8'hAA, 8'h55, 8'hFF, 0, 0, 1};
    vt[6]  = '{OP_INC, DEST_A, 8'hFF, 8'h12, 8'h00, 1, 1, 0};
    vt[7]  = '{OP_INC, DEST_D, 8'h7F, 8'h00, 8'h80, 0, 0, 1};
    vt[8]  = '{OP_ADD, DEST_A, 8'h80, 8'h80, 8'h00, 1, 1, 0};
    vt[9]  = '{OP_CLR, DEST_D, 8'h5A, 8'hA5, 8'h00, 1, 0, 0};
    vt[10] = '{OP_ADD, DEST_A, 8'h10, 8'h20, 8'h30, 0, 0, 0};

    put(3, 1'b0, OP_ADD, DEST_A, 8'h00, 8'h00);
    put(1, 1'b0, OP_ADD, DEST_A, 8'h00, 8'h00);
    put(15, 1'b0, OP_ADD, DEST_A, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", i3.busy, 0);
    chk("rst_done", i3.done, 0);
    chk("rst_ld", {i3.ldA, i3.ldD}, 0);
    chk("rst_result", i3.alu_result, 8'h00);
    chk("rst_flags", {i3.flag_z, i3.flag_c, i3.flag_s}, 3'b100);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 11; k++) begin
      sbq.push_back('{vt[k].r, vt[k].z, vt[k].cy, vt[k].s,
                      vt[k].dest});
      run_op(3, vt[k].op, vt[k].dest, vt[k].b, vt[k].c, "vec");
    end

    // start held high: one completion every SETTLE+2 cycles
    for (int k = 0; k < 3; k++)
      sbq.push_back('{8'h30, 1'b0, 1'b0, 1'b0, DEST_A});
    @(negedge clk);
    put(3, 1'b1, OP_ADD, DEST_A, 8'h10, 8'h20);
    dc = 0;
    last = -1;
    for (int cyc = 1; cyc <= 40 && dc < 3; cyc++) begin
      @(posedge clk);
      #1;
      if (i3.done) begin
        if (last >= 0) chk("held_period", cyc - last, 5);
        last = cyc;
        dc++;
        if (dc == 3) put(3, 1'b0, OP_ADD, DEST_A, 8'h10, 8'h20);
      end
    end
    chk("held_count", dc, 3);
    put(3, 1'b0, OP_ADD, DEST_A, 8'h10, 8'h20);
    repeat (3) @(posedge clk);

    // reset during settle aborts the INC
    @(negedge clk);
    put(3, 1'b1, OP_INC, DEST_A, 8'h7F, 8'h00);
    @(posedge clk);
    #1;
    put(3, 1'b0, OP_INC, DEST_A, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", i3.busy, 0);
    chk("abort_result", i3.alu_result, 8'h00);
    chk("abort_z", i3.flag_z, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);

    // reset wins over start in the same cycle
    @(negedge clk);
    rst = 1'b1;
    put(3, 1'b1, OP_XOR, DEST_D, 8'hAA, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_vs_start", i3.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    put(3, 1'b0, OP_XOR, DEST_D, 8'hAA, 8'h00);
    repeat (6) @(posedge clk);

    sbq.push_back('{8'hFF, 1'b0, 1'b0, 1'b1, DEST_D});
    run_op(3, OP_XOR, DEST_D, 8'hAA, 8'h55, "recover");

    run_op(1, OP_OR, DEST_A, 8'h0F, 8'hF0, "s1_or");
    chk("s1_or_res", res_of(1), 9'h0FF);
    run_op(1, OP_CLR, DEST_D, 8'h12, 8'h34, "s1_clr");
    chk("s1_clr_res", res_of(1), 9'h100);
    run_op(15, OP_OR, DEST_A, 8'h0F, 8'hF0, "s15_or");
    chk("s15_or_res", res_of(15), 9'h0FF);
    run_op(15, OP_CLR, DEST_A, 8'h12, 8'h34, "s15_clr");
    chk("s15_clr_res", res_of(15), 9'h100);

    repeat (3) @(posedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter SETTLE, default 3, relay settle time in clock cycles; legal range 1..15.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to execute one ALU operation.
REQ-005 SHALL have port op  input  3  function: 000 ADD, 001 INC, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 CLR.
REQ-006 SHALL have port dest  input  1  destination register: 0 = A, 1 = D.
REQ-007 SHALL have port b  input  8  operand from register B.
REQ-008 SHALL have port c  input  8  operand from register C.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port alu_result  output  8  registered result, feeds A/D register data input.
REQ-012 SHALL have ports ldA and ldD  output  1 each  one-cycle load strobes to registers A and D.
REQ-013 SHALL have ports flag_z, flag_c, flag_s  output  1 each  condition flags zero, carry, sign.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, WRITE.
REQ-015 In IDLE with start=1 SHALL capture op, dest, b, c, load settle counter with SETTLE-1, and enter SETTLE.
REQ-016 In SETTLE SHALL decrement counter each cycle and enter WRITE on the edge where counter is 0.
REQ-017 On the edge entering WRITE SHALL register alu_result and all three flags from captured operands.
REQ-018 In WRITE SHALL assert done and exactly one of ldA (dest=0) or ldD (dest=1) for one cycle, then return to IDLE.
REQ-019 Latency: start sampled at edge t -> done/ld strobe high in cycle t+SETTLE+1; busy high cycles t+1 .. t+SETTLE+1.
REQ-020 start SHALL be ignored in SETTLE and WRITE; no queuing; next accept earliest at first IDLE cycle after WRITE.
REQ-021 Changes on b, c, op, dest after capture SHALL NOT affect the in-flight result.
REQ-022 Arithmetic: ADD = b+c mod 256, carry = bit 8; INC = b+1 mod 256, carry = bit 8.
REQ-023 Logic: AND/OR/XOR bitwise b,c; NOT = ~b; SHL = left rotate of b by one (bit7 -> bit0); CLR = 0x00; flag_c = 0 for all these.
REQ-024 flag_z = (result == 0); flag_s = result[7]; flags update only on WRITE entry.
REQ-025 alu_result and flags SHALL hold last values outside WRITE until next completion.
REQ-026 ldA, ldD, done SHALL never assert outside WRITE; ldA and ldD SHALL never assert together.

Reset
REQ-027 reset SHALL force IDLE, counter 0, busy/done/ldA/ldD 0, alu_result 0x00, flag_z 1, flag_c 0, flag_s 0.
REQ-028 reset mid-operation SHALL abort with no ld strobe or done pulse; reset has priority over start in the same cycle.

Structure
REQ-029 alu_op_t (3-bit op enum), dest_t, and the state enum SHALL reside in shared package relay_pkg.
REQ-030 Combinational function (op, b, c -> result, carry) SHALL be a sub-module alu_core; alu_sequencer holds FSM, counter, result and flag registers.

Verification
REQ-031 SETTLE=3, ADD b=0xFF c=0x01 dest=1, start at t -> ldD and done high only in t+4, alu_result=0x00, Z=1 C=1 S=0.
REQ-032 SHL b=0x81 dest=0 -> alu_result=0x03, ldA pulse, C=0 S=0 Z=0; then NOT b=0x0F -> 0xF0, S=1.
REQ-033 start held high continuously with ADD 0x10+0x20 -> result 0x30; operations complete every SETTLE+2 cycles; no start accepted while busy.
REQ-034 Change b/c to 0x00 one cycle after accepting XOR 0xAA,0x55 -> result still 0xFF, S=1.
REQ-035 reset asserted in SETTLE of INC 0x7F -> no ldA/ldD/done, alu_result 0x00, Z=1, busy 0 next cycle.
REQ-036 SETTLE=1 and SETTLE=15 builds: CLR -> done at t+2 and t+16 respectively, alu_result 0x00, Z=1.
